// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one pipelined 16-bit divider among NREQ requesters
module div_arbiter #(
    parameter int NREQ        = 4,
    parameter int DIV_LATENCY = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_dividend,
    input  logic [16*NREQ-1:0]   req_divisor,
    output logic [15:0]          div_dividend,
    output logic [15:0]          div_divisor,
    input  logic [15:0]          div_quotient,
    input  logic [15:0]          div_reminder,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_quotient,
    output logic [15:0]          rsp_reminder,
    output logic                 rsp_div0,
    output logic                 busy
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NST = DIV_LATENCY + 1;
    // The response register counts as in flight, so up to DIV_LATENCY+2 ops can be outstanding.
    localparam int CW  = $clog2(DIV_LATENCY + 3);

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cand;
    logic          gnt_any;
    logic          xfer;
    logic [15:0]   sel_dvd;
    logic [15:0]   sel_dvs;
    int            j;

    logic          tag_valid [NST];
    logic [IW-1:0] tag_idx   [NST];
    logic          tag_div0  [NST];
    logic [15:0]   tag_dvd   [NST];

    logic [CW-1:0] inflight;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            cand = IW'(j);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer    = |(req_valid & req_ready);
    assign sel_dvd = req_dividend[int'(gnt_idx)*16 +: 16];
    assign sel_dvs = req_divisor[int'(gnt_idx)*16 +: 16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (xfer) begin
            ptr          <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            div_dividend <= sel_dvd;
            div_divisor  <= sel_dvs;
        end
    end

    // Tag stage s lines up with the divider's operands from s edges ago; the last stage meets its result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NST; s++) begin
                tag_valid[s] <= 1'b0;
                tag_idx[s]   <= '0;
                tag_div0[s]  <= 1'b0;
                tag_dvd[s]   <= '0;
            end
        end else begin
            tag_valid[0] <= xfer;
            tag_idx[0]   <= gnt_idx;
            tag_div0[0]  <= (sel_dvs == 16'h0000);
            tag_dvd[0]   <= sel_dvd;
            for (int s = 1; s < NST; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_idx[s]   <= tag_idx[s-1];
                tag_div0[s]  <= tag_div0[s-1];
                tag_dvd[s]   <= tag_dvd[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= '0;
            rsp_quotient <= '0;
            rsp_reminder <= '0;
            rsp_div0     <= 1'b0;
        end else if (tag_valid[NST-1]) begin
            rsp_valid    <= NREQ'(1) << tag_idx[NST-1];
            rsp_quotient <= tag_div0[NST-1] ? 16'hFFFF : div_quotient;
            rsp_reminder <= tag_div0[NST-1] ? tag_dvd[NST-1] : div_reminder;
            rsp_div0     <= tag_div0[NST-1];
        end else begin
            rsp_valid    <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (xfer && !(|rsp_valid)) begin
            inflight <= inflight + CW'(1);
        end else if (!xfer && (|rsp_valid)) begin
            inflight <= inflight - CW'(1);
        end
    end

    assign busy = (inflight != '0);

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - randomized and directed self-checking bench for div_arbiter
module tb_div_arbiter;

    localparam int N = 4;
    localparam int L = 16;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [16*N-1:0]   req_dividend;
    logic [16*N-1:0]   req_divisor;
    logic [15:0]       div_dividend;
    logic [15:0]       div_divisor;
    logic [15:0]       div_quotient;
    logic [15:0]       div_reminder;
    logic [N-1:0]      rsp_valid;
    logic [15:0]       rsp_quotient;
    logic [15:0]       rsp_reminder;
    logic              rsp_div0;
    logic              busy;

    div_arbiter #(.NREQ(N), .DIV_LATENCY(L)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_reminder (div_reminder),
        .rsp_valid    (rsp_valid),
        .rsp_quotient (rsp_quotient),
        .rsp_reminder (rsp_reminder),
        .rsp_div0     (rsp_div0),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in pipelined divider: result appears L edges after the operands change.
    logic [15:0] pq [L];
    logic [15:0] pr [L];
    always @(posedge clk) begin
        pq[0] <= (div_divisor == 16'h0) ? 16'h0 : div_dividend / div_divisor;
        pr[0] <= (div_divisor == 16'h0) ? 16'h0 : div_dividend % div_divisor;
        for (int i = 1; i < L; i++) begin
            pq[i] <= pq[i-1];
            pr[i] <= pr[i-1];
        end
    end
    assign div_quotient = pq[L-1];
    assign div_reminder = pr[L-1];

    typedef struct {
        int          idx;
        logic [15:0] q;
        logic [15:0] r;
        logic        d0;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc;
    int          m_ptr;
    int          m_gnt;
    logic [15:0] last_q, last_r, m_dvd, m_dvs;
    logic        last_d0;
    int          n_pass, n_total;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic rst, input logic [N-1:0] v,
                        input logic [16*N-1:0] a, input logic [16*N-1:0] b);
        exp_t        e;
        logic [N-1:0] exp_rv;
        logic [N-1:0] exp_rdy;
        logic [15:0]  dv, ds;
        int           g, jj;
        @(negedge clk);
        cyc++;
        while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_rv[sb[0].idx] = 1'b1;
            last_q  = sb[0].q;
            last_r  = sb[0].r;
            last_d0 = sb[0].d0;
        end
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("rsp_quotient", 64'(rsp_quotient), 64'(last_q));
        check("rsp_reminder", 64'(rsp_reminder), 64'(last_r));
        check("rsp_div0", 64'(rsp_div0), 64'(last_d0));
        check("busy", 64'(busy), 64'(sb.size() != 0));
        check("div_operands", {32'h0, div_dividend, div_divisor}, {32'h0, m_dvd, m_dvs});

        rst_n        = rst;
        req_valid    = v;
        req_dividend = a;
        req_divisor  = b;
        #1;
        m_gnt = -1;
        if (!rst) begin
            sb.delete();
            m_ptr = 0; last_q = '0; last_r = '0; last_d0 = 1'b0; m_dvd = '0; m_dvs = '0;
            check("rst_outputs",
                  {req_ready, rsp_valid, rsp_quotient, rsp_reminder, 7'h0, rsp_div0, busy},
                  64'h0);
            check("rst_div_operands", 64'({div_dividend, div_divisor}), 64'h0);
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                jj = (m_ptr + k) % N;
                if (g < 0 && v[jj]) g = jj;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (g >= 0) begin
                dv = a[16*g +: 16];
                ds = b[16*g +: 16];
                e.idx = g;
                e.d0  = (ds == 16'h0);
                e.q   = e.d0 ? 16'hFFFF : dv / ds;
                e.r   = e.d0 ? dv : dv % ds;
                e.due = cyc + L + 2;
                sb.push_back(e);
                m_dvd = dv;
                m_dvs = ds;
                m_ptr = (g + 1) % N;
                m_gnt = g;
            end
        end
    endtask

    function automatic logic [16*N-1:0] put(input int i, input logic [15:0] val);
        logic [16*N-1:0] x;
        x = '0;
        x[16*i +: 16] = val;
        return x;
    endfunction

    initial begin
        logic [N-1:0]    pend;
        logic [16*N-1:0] a, b;
        cyc = 0; m_ptr = 0; m_gnt = -1; n_pass = 0; n_total = 0;
        last_q = '0; last_r = '0; last_d0 = 1'b0; m_dvd = '0; m_dvs = '0;
        rst_n = 1'b0; req_valid = '0; req_dividend = '0; req_divisor = '0;

        for (int i = 0; i < 3; i++) step(1'b0, '1, '0, '0);

        // contention from pointer 0, each requester with its own operands
        a = {16'd4000, 16'd3000, 16'd2000, 16'd1000};
        b = {16'd7, 16'd13, 16'd3, 16'd250};
        pend = '1;
        for (int i = 0; i < N; i++) begin
            step(1'b1, pend, a, b);
            check("contention_grant", 64'(m_gnt), 64'(i));
            if (m_gnt >= 0) pend[m_gnt] = 1'b0;
        end
        for (int i = 0; i < L + 4; i++) step(1'b1, '0, '0, '0);

        step(1'b1, 4'b0001, put(0, 16'h03E9), put(0, 16'h00FA));
        for (int i = 0; i < L + 4; i++) step(1'b1, '0, '0, '0);

        for (int i = 0; i < 5; i++) step(1'b1, 4'b0010, put(1, 16'h03E9 + 16'(i)), put(1, 16'h00FA));
        for (int i = 0; i < L + 4; i++) step(1'b1, '0, '0, '0);

        step(1'b1, 4'b0100, put(2, 16'h1234), put(2, 16'h0000));
        for (int i = 0; i < L + 4; i++) step(1'b1, '0, '0, '0);

        for (int i = 0; i < 3; i++) step(1'b1, 4'b1000, put(3, 16'd500 + 16'(i)), put(3, 16'd9));
        for (int i = 0; i < L / 2 - 3; i++) step(1'b1, '0, '0, '0);
        step(1'b0, '0, '0, '0);
        step(1'b0, '1, '1, '1);
        for (int i = 0; i < L + 6; i++) step(1'b1, '0, '0, '0);

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                a[16*k +: 16] = 16'($urandom);
                b[16*k +: 16] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF) >> $urandom_range(0, 12));
            end
            step(($urandom_range(0, 99) != 0), N'($urandom), a, b);
        end
        for (int i = 0; i < L + 4; i++) step(1'b1, '0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
